calc_alu_seq: RTL
=================

// Module: calc_alu_seq
// PURPOSE
//  Parametrised successor of the two-function add/subtract calculator: W-bit operand registers A/B,
//  op select (ADD/SUB/AND/OR/XOR, optional iterative MUL), registered result and 4-bit condition codes.
//  Sits between switch/button front end and the existing hex-display decoders; drives Rout/CCout to them.
//  Adds Start/Busy/Done handshake and a multi-cycle shift-add multiplier the 8-bit adder version lacks.
// PARAMETERS
//  W   8   operand/result width in bits; legal range 4..32
// PORTS
//  CLK     in   1   single clock, all state on rising edge
//  CLR     in   1   synchronous, active-high reset
//  X       in   W   data input, loaded into A and/or B
//  LoadA   in   1   load X into A at this edge (ignored while Busy)
//  LoadB   in   1   load X into B at this edge (ignored while Busy)
//  Op      in   3   opcode, sampled with Start: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 MUL,6-7 invalid
//  Start   in   1   begin operation on current A,B,Op (ignored while Busy)
//  Rout    out  W   registered result
//  CCout   out  4   registered codes {Ovr,Cout,Neg,Zero} = bits [3:0]
//  Busy    out  1   high while MUL iterates
//  Done    out  1   one-cycle pulse when Rout/CCout updated (or op rejected)
//  OpErr   out  1   high with Done when opcode was invalid
// BEHAVIOUR
//  - Reset (CLR=1 at edge): A,B,Rout,CCout=0; Busy,Done,OpErr=0; FSM->IDLE. Overrides all inputs; aborts MUL, no Done.
//  - FSM: IDLE, MUL_RUN. IDLE+Start+Op in 0..4 -> stay IDLE, compute at Start edge;
//    IDLE+Start+Op=5 -> MUL_RUN; MUL_RUN for exactly W cycles -> IDLE.
//  - Latency: Start sampled edge n: single-cycle ops -> Rout/CCout/Done valid cycle n+1, Busy never set.
//    MUL -> Busy=1 cycles n+1..n+W; Rout/CCout/Done valid cycle n+W+1, Busy=0 then.
//  - Operands: A,B,Op copied at Start edge; LoadA/LoadB same edge as Start load new X but op uses old A/B.
//  - LoadA and LoadB together: both load X. Start/LoadA/LoadB while Busy: ignored entirely (no queueing).
//  - ADD: A+B mod 2^W; Cout=carry out; Ovr=signed overflow.
//  - SUB: A+~B+1; Cout=carry out (1 = no borrow); Ovr=signed overflow.
//  - AND/OR/XOR: bitwise; Cout=0, Ovr=0.
//  - MUL: unsigned A*B, one shift-add step/cycle; Rout=low W bits; Cout=1 iff high W bits nonzero; Ovr=0.
//  - All ops: Neg=Rout[W-1], Zero=(Rout==0).
//  - Invalid Op: Rout/CCout unchanged; Done=1 and OpErr=1 in cycle n+1.
//  - Done/OpErr low at all other times; Rout/CCout hold between operations.
// CONFIGURATION
//  CALC_MUL_EN defined: Op=5 runs the multiplier as above.
//  CALC_MUL_EN undefined: no multiplier logic; Op=5 treated as invalid (OpErr); Busy tied 0; MUL_RUN unreachable.
// STRUCTURE
//  Package calc_pkg: opcode enum (OP_ADD..OP_MUL), CC bit index constants (CC_OVR=3,CC_COUT=2,
//   CC_NEG=1,CC_ZERO=0), FSM state enum.
//  One sub-module: calc_mul_seq (W-param shift-add multiplier: start, 2W-bit product, done),
//   instantiated only under CALC_MUL_EN. Single-cycle ops + CC logic stay in top.
// TESTING
//  1 W=8, A=0x7F,B=0x01,ADD -> cycle n+1: Rout=0x80, CCout=4'b1010, Done=1 one cycle, Busy=0.
//  2 A=0x05,B=0x05,SUB -> Rout=0x00, CCout=4'b0101; A=0x00,B=0x01,SUB -> Rout=0xFF, CCout=4'b0010.
//  3 MUL_EN: A=0x10,B=0x10,MUL -> Busy cycles n+1..n+8, cycle n+9: Rout=0x00, CCout=4'b0101;
//    A=0x0C,B=0x0B -> Rout=0x84, CCout=4'b0010.
//  4 LoadA X=0x33 with Start ADD (old A=0x01,B=0x02) -> Rout=0x03, A=0x33 afterwards;
//    LoadB/Start during Busy -> B and Rout unaffected, no extra Done.
//  5 CLR at cycle n+3 of MUL -> next cycle Rout=0,CCout=0,Busy=0, no Done pulse ever for that op.
//  6 Op=7 with Rout=0x42 -> Done=1,OpErr=1, Rout=0x42 held; without CALC_MUL_EN Op=5 behaves the same.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : calc_pkg                                                      |
// | Description : Opcodes, condition-code bit positions and FSM states shared  |
// |               by the sequential calculator ALU and its multiplier.         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5
    } op_e;

    localparam int CC_OVR  = 3;
    localparam int CC_COUT = 2;
    localparam int CC_NEG  = 1;
    localparam int CC_ZERO = 0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_mul_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : calc_mul_seq                                                  |
// | Description : Unsigned W x W shift-add multiplier, one partial product per  |
// |               cycle; o_done/o_product present the final step combinationally|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module calc_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_product,
    output logic           o_done
);

    localparam int             c_cw   = $clog2(W);
    localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);

    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic [c_cw-1:0] r_cnt;
    logic            r_run;
    logic [2*W-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
                r_run <= 1'b0;
            end
        end
    end

    // The last step is exposed unregistered so the caller latches it on the W-th edge.
    assign o_done    = r_run && (r_cnt == c_last);
    assign o_product = w_acc_next;

endmodule : calc_mul_seq
`default_nettype wire

// File: rtl/calc_alu_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : calc_alu_seq                                                  |
// | Description : W-bit register calculator: ADD/SUB/AND/OR/XOR in one cycle,  |
// |               optional iterative MUL, with Start/Busy/Done handshake.      |
// |               Define CALC_MUL_EN to build in the multiplier (Op=5).        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [W-1:0] X,
    input  logic         LoadA,
    input  logic         LoadB,
    input  logic [2:0]   Op,
    input  logic         Start,
    output logic [W-1:0] Rout,
    output logic [3:0]   CCout,
    output logic         Busy,
    output logic         Done,
    output logic         OpErr
);

`ifdef CALC_MUL_EN
    localparam bit c_mul_en = 1'b1;
`else
    localparam bit c_mul_en = 1'b0;
`endif

    state_e         r_state;
    state_e         w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_rout;
    logic [3:0]     r_cc;
    logic           r_done;
    logic           r_operr;

    logic           w_idle;
    logic           w_op_mul;
    logic           w_op_valid;
    logic           w_mul_done;
    logic [2*W-1:0] w_mul_prod;
    logic [W:0]     w_add;
    logic [W:0]     w_sub;
    logic [W-1:0]   w_res;
    logic           w_cout;
    logic           w_ovr;
    logic [3:0]     w_cc;
    logic [3:0]     w_mul_cc;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_op_mul   = c_mul_en && (Op == OP_MUL);
    assign w_op_valid = (Op <= OP_XOR) || w_op_mul;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (Start && w_op_mul) w_state_next = ST_MUL_RUN;
            ST_MUL_RUN: if (w_mul_done)        w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} + {1'b0, ~r_b} + {{W{1'b0}}, 1'b1};

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovr  = 1'b0;
        case (Op)
            OP_ADD: begin
                w_res  = w_add[W-1:0];
                w_cout = w_add[W];
                w_ovr  = (r_a[W-1] == r_b[W-1]) && (w_add[W-1] != r_a[W-1]);
            end
            OP_SUB: begin
                w_res  = w_sub[W-1:0];
                w_cout = w_sub[W];
                w_ovr  = (r_a[W-1] != r_b[W-1]) && (w_sub[W-1] != r_a[W-1]);
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_cc              = '0;
        w_cc[CC_OVR]      = w_ovr;
        w_cc[CC_COUT]     = w_cout;
        w_cc[CC_NEG]      = w_res[W-1];
        w_cc[CC_ZERO]     = (w_res == '0);
        w_mul_cc          = '0;
        w_mul_cc[CC_COUT] = (w_mul_prod[2*W-1:W] != '0);
        w_mul_cc[CC_NEG]  = w_mul_prod[W-1];
        w_mul_cc[CC_ZERO] = (w_mul_prod[W-1:0] == '0);
    end

`ifdef CALC_MUL_EN
    calc_mul_seq #(
        .W (W)
    ) u_mul (
        .clk       (CLK),
        .rst       (CLR),
        .i_start   (w_idle && Start && w_op_mul),
        .i_a       (r_a),
        .i_b       (r_b),
        .o_product (w_mul_prod),
        .o_done    (w_mul_done)
    );
    assign Busy = ~w_idle;
`else
    assign w_mul_prod = '0;
    assign w_mul_done = 1'b0;
    assign Busy       = 1'b0;
`endif

    // Operands are read before the same-edge loads take effect, so Start uses old A/B.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_a     <= '0;
            r_b     <= '0;
            r_rout  <= '0;
            r_cc    <= '0;
            r_done  <= 1'b0;
            r_operr <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_operr <= 1'b0;
            if (w_idle) begin
                if (LoadA) r_a <= X;
                if (LoadB) r_b <= X;
                if (Start) begin
                    if (!w_op_valid) begin
                        r_done  <= 1'b1;
                        r_operr <= 1'b1;
                    end else if (!w_op_mul) begin
                        r_rout <= w_res;
                        r_cc   <= w_cc;
                        r_done <= 1'b1;
                    end
                end
            end else if (w_mul_done) begin
                r_rout <= w_mul_prod[W-1:0];
                r_cc   <= w_mul_cc;
                r_done <= 1'b1;
            end
        end
    end

    assign Rout  = r_rout;
    assign CCout = r_cc;
    assign Done  = r_done;
    assign OpErr = r_operr;

endmodule : calc_alu_seq
`default_nettype wire
